// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: streams config words LSB-first onto a CLB slice config chain.
module cfg_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 12,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              cclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_bit,
  output logic              cfg_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_cnt
);
  localparam int BL_W = $clog2(WORD_W + 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BL_W-1:0]   bits_left_q, bits_left_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              last_chain, last_word;
  assign last_chain = bit_cnt_q == CNT_W'(CHAIN_LEN - 1);
  assign last_word  = bits_left_q == BL_W'(1);
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bits_left_q <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end
  // abort outranks everything, including a simultaneous start
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    bit_cnt_d   = bit_cnt_q;
    if (abort) begin
      state_d     = IDLE;
      shreg_d     = '0;
      bits_left_d = '0;
      bit_cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_d   = LOAD;
          bit_cnt_d = '0;
        end
        LOAD: if (word_valid) begin
          state_d     = SHIFT;
          shreg_d     = word_in;
          bits_left_d = BL_W'(WORD_W);
        end
        SHIFT: begin
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
          shreg_d     = shreg_q >> 1;
          bits_left_d = bits_left_q - BL_W'(1);
          if (last_chain) state_d = DONE;
          else if (last_word && word_valid) begin
            shreg_d     = word_in;
            bits_left_d = BL_W'(WORD_W);
          end else if (last_word) state_d = LOAD;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    busy       = state_q == LOAD || state_q == SHIFT;
    done       = state_q == DONE;
    cfg_en     = state_q == SHIFT;
    cfg_bit    = state_q == SHIFT ? shreg_q[0] : 1'b0;
    word_ready = !abort && (state_q == LOAD || (state_q == SHIFT && last_word && !last_chain));
    bit_cnt    = bit_cnt_q;
  end
endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader: directed stimulus with queued expectations checked by a negedge monitor.
module tb_cfg_chain_loader;
  logic cclk = 0, rst_n = 0;
  logic start0 = 0, abort0 = 0, v0 = 0, start1 = 0, abort1 = 0, v1 = 0;
  logic [7:0] w0 = 0, w1 = 0;
  logic wr0, en0, bit0, busy0, done0, wr1, en1, bit1, busy1, done1;
  logic [3:0] cnt0, cnt1;
  typedef struct {string name; int sel; int exp;} chk_t;
  chk_t chk_q[$];
  bit bq0[$], bq1[$];
  bit seq0[12] = '{1,0,1,0,0,1,0,1,0,0,1,1};
  int n_cmp = 0, n_fail = 0, hs0 = 0, hs1 = 0, ec0 = 0, ec1 = 0;

  always #5 cclk = ~cclk;

  cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(12)) u0 (
    .cclk(cclk), .rst_n(rst_n), .start(start0), .abort(abort0), .word_in(w0),
    .word_valid(v0), .word_ready(wr0), .cfg_bit(bit0), .cfg_en(en0),
    .busy(busy0), .done(done0), .bit_cnt(cnt0));
  cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(8)) u1 (
    .cclk(cclk), .rst_n(rst_n), .start(start1), .abort(abort1), .word_in(w1),
    .word_valid(v1), .word_ready(wr1), .cfg_bit(bit1), .cfg_en(en1),
    .busy(busy1), .done(done1), .bit_cnt(cnt1));

  function automatic int st(input bit wr, en, bz, dn, input int cnt);
    return int'({wr, en, bz, dn, 4'(cnt)});
  endfunction

  // status vector layout: {word_ready, cfg_en, busy, done, bit_cnt}
  always @(negedge cclk) begin
    chk_t c;
    int a;
    bit e;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.sel)
        0: a = int'({wr0, en0, busy0, done0, cnt0});
        1: a = int'({wr1, en1, busy1, done1, cnt1});
        2: a = hs0;
        3: a = hs1;
        4: a = ec0;
        5: a = ec1;
        6: a = bq0.size();
        default: a = bq1.size();
      endcase
      n_cmp++;
      if (a != c.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, a, c.exp);
      end
    end
    if (en0) begin
      n_cmp++;
      if (bq0.size() == 0) begin
        n_fail++;
        $display("FAIL u0 cfg_bit: got %0b with cfg_en high, expected no shift", bit0);
      end else begin
        e = bq0.pop_front();
        if (bit0 !== e) begin
          n_fail++;
          $display("FAIL u0 cfg_bit: got %0b expected %0b", bit0, e);
        end
      end
    end
    if (en1) begin
      n_cmp++;
      if (bq1.size() == 0) begin
        n_fail++;
        $display("FAIL u1 cfg_bit: got %0b with cfg_en high, expected no shift", bit1);
      end else begin
        e = bq1.pop_front();
        if (bit1 !== e) begin
          n_fail++;
          $display("FAIL u1 cfg_bit: got %0b expected %0b", bit1, e);
        end
      end
    end
    ec0 += int'(en0);
    ec1 += int'(en1);
    hs0 += int'(v0 && wr0);
    hs1 += int'(v1 && wr1);
  end

  task automatic tick;
    @(posedge cclk);
    #1;
  endtask

  task automatic want(input string n, input int sel, input int v);
    chk_q.push_back('{n, sel, v});
  endtask

  task automatic push0(input int n);
    for (int i = 0; i < n; i++) bq0.push_back(seq0[i]);
  endtask

  task automatic full_load(input string tag, input bit sh_start, input int pre);
    start0 = 1;
    want({tag, " start"}, 0, pre);
    tick;
    start0 = 0; v0 = 1; w0 = 8'hA5;
    push0(12);
    want({tag, " load"}, 0, st(1, 0, 1, 0, 0));
    tick;
    w0 = 8'h3C;
    for (int i = 0; i < 12; i++) begin
      start0 = sh_start && i == 3;
      want($sformatf("%s bit%0d", tag, i), 0, st(i == 7, 1, 1, 0, i));
      tick;
    end
    start0 = 0; v0 = 0;
    want({tag, " done"}, 0, st(0, 0, 0, 1, 12));
  endtask

  initial begin
    repeat (2) tick;
    want("reset u0", 0, 0);
    want("reset u1", 1, 0);
    rst_n = 1;
    tick;
    full_load("b2b", 0, 0);
    want("b2b handshakes", 2, 2);
    want("b2b cfg_en cycles", 4, 12);
    tick;
    start0 = 1;
    want("stall start", 0, st(0, 0, 0, 1, 12));
    tick;
    start0 = 0; v0 = 1; w0 = 8'hA5;
    push0(12);
    want("stall load", 0, st(1, 0, 1, 0, 0));
    tick;
    v0 = 0;
    for (int i = 0; i < 8; i++) begin
      want($sformatf("stall bit%0d", i), 0, st(i == 7, 1, 1, 0, i));
      tick;
    end
    for (int k = 0; k < 3; k++) begin
      want($sformatf("stall wait%0d", k), 0, st(1, 0, 1, 0, 8));
      tick;
    end
    v0 = 1; w0 = 8'h3C;
    want("stall resume", 0, st(1, 0, 1, 0, 8));
    tick;
    v0 = 0;
    for (int i = 8; i < 12; i++) begin
      want($sformatf("stall bit%0d", i), 0, st(0, 1, 1, 0, i));
      tick;
    end
    want("stall done", 0, st(0, 0, 0, 1, 12));
    want("stall handshakes", 2, 4);
    want("stall cfg_en cycles", 4, 24);
    tick;
    start0 = 1;
    want("abort start", 0, st(0, 0, 0, 1, 12));
    tick;
    start0 = 0; v0 = 1; w0 = 8'hA5;
    push0(6);
    want("abort load", 0, st(1, 0, 1, 0, 0));
    tick;
    v0 = 0;
    for (int i = 0; i < 5; i++) begin
      want($sformatf("abort bit%0d", i), 0, st(0, 1, 1, 0, i));
      tick;
    end
    abort0 = 1;
    want("abort cycle", 0, st(0, 1, 1, 0, 5));
    tick;
    abort0 = 0;
    want("abort idle", 0, 0);
    want("abort handshakes", 2, 5);
    want("abort cfg_en cycles", 4, 30);
    tick;
    full_load("reload", 1, 0);
    want("reload handshakes", 2, 7);
    want("reload cfg_en cycles", 4, 42);
    tick;
    start0 = 1; abort0 = 1; v0 = 1; w0 = 8'h77;
    want("start+abort in done", 0, st(0, 0, 0, 1, 12));
    tick;
    start0 = 0; abort0 = 0;
    want("start+abort idle", 0, 0);
    tick;
    want("start+abort idle hold", 0, 0);
    want("start+abort handshakes", 2, 7);
    tick;
    v0 = 0; start0 = 1;
    want("rst start", 0, 0);
    tick;
    start0 = 0; v0 = 1; w0 = 8'hA5;
    push0(3);
    want("rst load", 0, st(1, 0, 1, 0, 0));
    tick;
    v0 = 0;
    for (int i = 0; i < 3; i++) begin
      want($sformatf("rst bit%0d", i), 0, st(0, 1, 1, 0, i));
      tick;
    end
    #2 rst_n = 0;
    want("rst async drop", 0, 0);
    tick;
    want("rst held", 0, 0);
    tick;
    rst_n = 1;
    want("rst released", 0, 0);
    tick;
    want("rst idle", 0, 0);
    want("rst cfg_en cycles", 4, 45);
    want("rst handshakes", 2, 8);
    want("u0 bits left over", 6, 0);
    tick;
    start1 = 1;
    want("fit start", 1, 0);
    tick;
    start1 = 0; v1 = 1; w1 = 8'hFF;
    for (int i = 0; i < 8; i++) bq1.push_back(1'b1);
    want("fit load", 1, st(1, 0, 1, 0, 0));
    tick;
    w1 = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      want($sformatf("fit bit%0d", i), 1, st(0, 1, 1, 0, i));
      tick;
    end
    want("fit done", 1, st(0, 0, 0, 1, 8));
    tick;
    want("fit done hold", 1, st(0, 0, 0, 1, 8));
    tick;
    want("fit handshakes", 3, 1);
    want("fit cfg_en cycles", 5, 8);
    want("u1 bits left over", 7, 0);
    v1 = 0;
    tick;
    @(negedge cclk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Sequences the block-style configuration chain of the CLB slice: F7/F8 mux-select config bits and adjacent config registers.
- Accepts configuration words over a valid/ready stream and serialises them LSB-first onto the chain, one bit per enabled cycle.
- Counts exactly CHAIN_LEN bits, then reports done.
- Sits between the fabric-level bitstream fetcher and the per-slice config_in/cen pins.

Parameters:
- WORD_W, default 8: width of incoming config word; must be ≥ 1.
- CHAIN_LEN, default 12: number of config bits in the chain; must be ≥ 1.
- CNT_W, default $clog2(CHAIN_LEN+1): width of the bit counter (derived; do not override).

Ports:
- cclk, input, 1: config clock; all state updates on posedge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: single-cycle request to begin a load.
- abort, input, 1: cancel an in-progress load.
- word_in, input, WORD_W: config word, bit 0 shifted first.
- word_valid, input, 1: word_in valid.
- word_ready, output, 1: loader accepts word_in this cycle.
- cfg_bit, output, 1: serial data to the chain config_in.
- cfg_en, output, 1: chain shift enable (drives cen).
- busy, output, 1: high in LOAD or SHIFT.
- done, output, 1: high in DONE.
- bit_cnt, output, CNT_W: bits shifted so far in the current load.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; shreg=0; bits_left=0.
  - bit_cnt=0; cfg_bit=0; cfg_en=0; word_ready=0; busy=0; done=0.
- States: IDLE, LOAD, SHIFT, DONE. Outputs are combinational from registered state/shreg, with no extra latency.
- IDLE:
  - word_ready=0; cfg_en=0.
  - start=1 → LOAD next cycle, with bit_cnt cleared to 0.
- LOAD:
  - word_ready=1; cfg_en=0.
  - On word_valid&&word_ready: shreg←word_in; bits_left←WORD_W; → SHIFT.
  - Otherwise stay in LOAD (stall; chain holds).
- SHIFT, every cycle:
  - cfg_en=1; cfg_bit=shreg[0].
  - Next cycle: shreg←shreg>>1; bits_left−1; bit_cnt+1.
- Last bit of the chain (bit_cnt==CHAIN_LEN−1):
  - → DONE; word_ready=0.
  - Unused upper bits of the final word are discarded.
- Last bit of a word (bits_left==1) when the chain is not complete:
  - word_ready=1 in this same cycle (prefetch).
  - If word_valid: load the new word, bits_left←WORD_W, stay in SHIFT. The next bit goes out the following cycle with no bubble.
  - Else → LOAD.
- word_ready=0 in SHIFT except in the prefetch cycle.
- DONE:
  - done=1; busy=0; cfg_en=0; bit_cnt holds CHAIN_LEN.
  - start → LOAD with bit_cnt cleared.
- abort in LOAD or SHIFT:
  - → IDLE next cycle; bit_cnt←0; shreg←0.
  - cfg_en is still driven in the abort cycle only if already in SHIFT, so the chain contents are partial and undefined.
  - Any word offered in that cycle is not accepted: word_ready forced 0 when abort=1.
- abort and start together: abort wins; state → IDLE.
- start while busy: ignored.
- abort in IDLE/DONE: → IDLE, done cleared.
- Total cfg_en-high cycles per completed load = CHAIN_LEN exactly.
- Words consumed per load = ceil(CHAIN_LEN/WORD_W).
- rst_n asserted mid-load: immediate return to the reset values above; cfg_en drops asynchronously.

Test Plan:
- Back-to-back load, CHAIN_LEN=12, WORD_W=8:
  - Stimulus: start; word_valid held high with 0xA5 then 0x3C.
  - cfg_bit sequence: 1,0,1,0,0,1,0,1,0,0,1,1.
  - cfg_en high for 12 contiguous cycles.
  - done=1 the cycle after the last bit; bit_cnt=12; exactly 2 handshakes.
- Stalled stream: same words, but word_valid low for 3 cycles after the first word.
  - State enters LOAD; cfg_en low for those 3 cycles; word_ready high.
  - Resumes with bit 0 of 0x3C; total cfg_en cycles = 12.
- Abort at bit_cnt=5:
  - Next cycle: state IDLE, cfg_en=0, bit_cnt=0, done=0, word_ready=0.
  - A new start performs a full 12-bit load correctly.
- Simultaneous start+abort from DONE: → IDLE, done=0, no word accepted. start while in SHIFT: sequence unaffected.
- Async reset mid-SHIFT (rst_n low between clock edges): cfg_en, busy, word_ready fall immediately; all outputs hold reset values until start.
- CHAIN_LEN=8, WORD_W=8 (exact fit):
  - One word 0xFF gives 8 ones; no prefetch word_ready in the final bit cycle.
  - done follows; a second word offered is never accepted.
